// File: rtl/pmu_clock_ctrl.sv
// Power-management clock controller: shared down-counting dividers feed per-channel
// OFF/FULL/DIV clocks; config changes land only while the channel clock is low.
module pmu_clock_ctrl #(
    parameter int unsigned          CHANNELS      = 3,
    parameter int unsigned          DIVIDERS      = 3,
    parameter int unsigned          DIV_WIDTH     = 21,
    parameter logic [DIV_WIDTH-1:0] DIV_DEFAULT   = DIV_WIDTH'(21'h5000),
    parameter logic [1:0]           RESET_MODE    = 2'b01,
    parameter int unsigned          TICK_CYCLES   = 12000000,
    parameter logic [7:0]           TIMER_DEFAULT = 8'd20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_addr,
    input  logic [23:0]         cfg_data,
    output logic [CHANNELS-1:0] ch_clk,
    output logic [CHANNELS-1:0] ch_ce,
    output logic [CHANNELS-1:0] ch_full,
    output logic                timer_evt
);
    localparam int unsigned         LP_PRE_W   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [LP_PRE_W-1:0] LP_PRE_MAX = LP_PRE_W'(TICK_CYCLES - 1);
    localparam logic [4:0]          LP_N_CH    = 5'(CHANNELS);
    localparam logic [4:0]          LP_N_DIV   = 5'(DIVIDERS);
    localparam logic [1:0]          MODE_FULL  = 2'b01;
    localparam logic [1:0]          MODE_DIV   = 2'b10;

    logic [DIV_WIDTH-1:0] r_div_cnt [DIVIDERS];
    logic [DIV_WIDTH-1:0] r_div_rld [DIVIDERS];
    logic [DIVIDERS-1:0]  w_tc;

    logic [1:0]          r_mode      [CHANNELS];
    logic [3:0]          r_sel       [CHANNELS];
    logic [1:0]          r_pend_mode [CHANNELS];
    logic [3:0]          r_pend_sel  [CHANNELS];
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] r_ch_clk;
    logic [CHANNELS-1:0] r_ch_ce;
    logic [CHANNELS-1:0] r_ch_full;
    logic                r_cfg_ready;

    logic [1:0]          w_mode_nx  [CHANNELS];
    logic [3:0]          w_sel_nx   [CHANNELS];
    logic [1:0]          w_pmode_nx [CHANNELS];
    logic [3:0]          w_psel_nx  [CHANNELS];
    logic [CHANNELS-1:0] w_pend_nx;
    logic [CHANNELS-1:0] w_clk_nx;
    logic [CHANNELS-1:0] w_ce_nx;
    logic [CHANNELS-1:0] w_full_nx;
    logic [CHANNELS-1:0] w_sel_tc;
    logic                w_swap_take;
    logic [1:0]          w_swap_mode;
    logic [3:0]          w_swap_sel;

    logic [LP_PRE_W-1:0] r_presc;
    logic [7:0]          r_sec;
    logic [7:0]          r_period;
    logic                r_tmr_en;
    logic [3:0]          r_tgt;
    logic [1:0]          r_alt_mode;
    logic [3:0]          r_alt_sel;
    logic                r_timer_evt;

    logic       w_wr;
    logic       w_wr_ch;
    logic       w_wr_tmr;
    logic       w_tick;
    logic       w_expire;
    logic [3:0] w_ch_idx;
    logic [3:0] w_ch_sel;
    logic [1:0] w_ch_mode;
    logic       w_unused;

    // Config decode; DIV configs pointing at a missing divider are dropped.
    assign w_wr      = cfg_valid && r_cfg_ready;
    assign w_ch_idx  = cfg_data[11:8];
    assign w_ch_mode = cfg_data[1:0];
    assign w_ch_sel  = cfg_data[5:2];
    assign w_wr_ch   = w_wr && (cfg_addr == 4'h8) && ({1'b0, w_ch_idx} < LP_N_CH)
                       && !((w_ch_mode == MODE_DIV) && ({1'b0, w_ch_sel} >= LP_N_DIV));
    assign w_wr_tmr  = w_wr && (cfg_addr == 4'h9);
    assign w_tick    = r_tmr_en && (r_presc == '0);
    assign w_expire  = w_tick && (r_sec == '0);
    assign w_unused  = ^cfg_data;

    always_comb begin : tc_decode
        w_tc = '0;
        for (int d = 0; d < DIVIDERS; d++) begin
            w_tc[d] = (r_div_cnt[d] == '0);
        end
    end

    always_comb begin : sel_tc_mux
        w_sel_tc = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int d = 0; d < DIVIDERS; d++) begin
                if (r_sel[c] == 4'(d)) begin
                    w_sel_tc[c] = w_tc[d];
                end
            end
        end
    end

    // A new write beats a timer swap on the same channel; pending configs wait for ch_clk low.
    always_comb begin : ch_next
        w_pend_nx   = r_pend;
        w_clk_nx    = '0;
        w_ce_nx     = '0;
        w_full_nx   = '0;
        w_swap_take = 1'b0;
        w_swap_mode = '0;
        w_swap_sel  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_mode_nx[c]  = r_mode[c];
            w_sel_nx[c]   = r_sel[c];
            w_pmode_nx[c] = r_pend_mode[c];
            w_psel_nx[c]  = r_pend_sel[c];
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_wr_ch && (w_ch_idx == 4'(c))) begin
                w_pend_nx[c]  = 1'b1;
                w_pmode_nx[c] = w_ch_mode;
                w_psel_nx[c]  = w_ch_sel;
            end else if (w_expire && (r_tgt == 4'(c))) begin
                w_pend_nx[c]  = 1'b1;
                w_pmode_nx[c] = r_alt_mode;
                w_psel_nx[c]  = r_alt_sel;
                w_swap_take   = 1'b1;
                w_swap_mode   = r_mode[c];
                w_swap_sel    = r_sel[c];
            end
            if (w_pend_nx[c] && !r_ch_clk[c]) begin
                w_mode_nx[c] = w_pmode_nx[c];
                w_sel_nx[c]  = w_psel_nx[c];
                w_pend_nx[c] = 1'b0;
            end else begin
                w_clk_nx[c] = (r_mode[c] == MODE_DIV) && (r_ch_clk[c] ^ w_sel_tc[c]);
                w_ce_nx[c]  = (r_mode[c] == MODE_DIV) && w_sel_tc[c] && !r_ch_clk[c];
            end
            w_full_nx[c] = (w_mode_nx[c] == MODE_FULL);
        end
    end

    // Reload writes only land in the reload register, so the running count is untouched.
    always_ff @(posedge clk) begin : div_regs
        for (int d = 0; d < DIVIDERS; d++) begin
            if (reset) begin
                r_div_cnt[d] <= DIV_DEFAULT;
                r_div_rld[d] <= DIV_DEFAULT;
            end else begin
                r_div_cnt[d] <= w_tc[d] ? r_div_rld[d] : (r_div_cnt[d] - DIV_WIDTH'(1));
                if (w_wr && (cfg_addr == 4'(d))) begin
                    r_div_rld[d] <= cfg_data[DIV_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin : ch_regs
        if (reset) begin
            r_pend      <= '0;
            r_ch_clk    <= '0;
            r_ch_ce     <= '0;
            r_ch_full   <= {CHANNELS{RESET_MODE == MODE_FULL}};
            r_cfg_ready <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                r_mode[c]      <= RESET_MODE;
                r_sel[c]       <= '0;
                r_pend_mode[c] <= '0;
                r_pend_sel[c]  <= '0;
            end
        end else begin
            r_pend      <= w_pend_nx;
            r_ch_clk    <= w_clk_nx;
            r_ch_ce     <= w_ce_nx;
            r_ch_full   <= w_full_nx;
            r_cfg_ready <= ~|w_pend_nx;
            for (int c = 0; c < CHANNELS; c++) begin
                r_mode[c]      <= w_mode_nx[c];
                r_sel[c]       <= w_sel_nx[c];
                r_pend_mode[c] <= w_pmode_nx[c];
                r_pend_sel[c]  <= w_psel_nx[c];
            end
        end
    end

    // Prescaler plus seconds counter; both are parked at their reload values while disabled.
    always_ff @(posedge clk) begin : timer_regs
        if (reset) begin
            r_presc     <= LP_PRE_MAX;
            r_sec       <= TIMER_DEFAULT;
            r_period    <= TIMER_DEFAULT;
            r_tmr_en    <= 1'b0;
            r_tgt       <= '0;
            r_alt_mode  <= '0;
            r_alt_sel   <= '0;
            r_timer_evt <= 1'b0;
        end else begin
            r_timer_evt <= w_expire;
            if (w_wr_tmr) begin
                r_period   <= cfg_data[7:0];
                r_tmr_en   <= cfg_data[8];
                r_tgt      <= cfg_data[12:9];
                r_alt_mode <= cfg_data[14:13];
                r_alt_sel  <= cfg_data[18:15];
                r_presc    <= LP_PRE_MAX;
                r_sec      <= cfg_data[7:0];
            end else begin
                if (w_swap_take) begin
                    r_alt_mode <= w_swap_mode;
                    r_alt_sel  <= w_swap_sel;
                end
                if (!r_tmr_en) begin
                    r_presc <= LP_PRE_MAX;
                    r_sec   <= r_period;
                end else if (w_tick) begin
                    r_presc <= LP_PRE_MAX;
                    r_sec   <= (r_sec == '0) ? r_period : (r_sec - 8'd1);
                end else begin
                    r_presc <= r_presc - LP_PRE_W'(1);
                end
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign ch_clk    = r_ch_clk;
    assign ch_ce     = r_ch_ce;
    assign ch_full   = r_ch_full;
    assign timer_evt = r_timer_evt;

endmodule

// File: tb/tb_pmu_clock_ctrl.sv
// Directed bench for pmu_clock_ctrl: divider periods, glitch-safe apply, timer swap,
// write-beats-swap collision and ignored writes.
module tb_pmu_clock_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic [2:0]  ch_clk;
    logic [2:0]  ch_ce;
    logic [2:0]  ch_full;
    logic        timer_evt;

    int n_checks = 0;
    int n_errors = 0;

    pmu_clock_ctrl #(
        .CHANNELS    (3),
        .DIVIDERS    (3),
        .DIV_WIDTH   (21),
        .TICK_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .ch_clk    (ch_clk),
        .ch_ce     (ch_ce),
        .ch_full   (ch_full),
        .timer_evt (timer_evt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the request until accepted; returns one cycle after the accepting edge.
    task automatic cfg_write(input logic [3:0] addr, input logic [23:0] data);
        int w;
        w         = 0;
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_valid = 1'b1;
        while (cfg_ready !== 1'b1 && w < 64) begin
            step(1);
            w++;
        end
        check_val("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        step(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int  k;
        int  hi;
        int  ce;
        int  evts;
        logic seen;

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        step(8);
        check_val("rst_full",  32'(ch_full),   32'd7);
        check_val("rst_clk",   32'(ch_clk),    32'd0);
        check_val("rst_ce",    32'(ch_ce),     32'd0);
        check_val("rst_ready", 32'(cfg_ready), 32'd1);
        check_val("rst_evt",   32'(timer_evt), 32'd0);
        reset = 1'b0;

        // div0 reload 3, div1 reload 1; ch0 DIV/div0, ch1 DIV/div1 (clocks low -> immediate)
        cfg_write(4'h0, 24'd3);
        cfg_write(4'h1, 24'd1);
        cfg_write(4'h8, 24'h000002);
        check_val("ch0_div_applied", 32'(ch_full), 32'd6);
        cfg_write(4'h8, 24'h000106);
        check_val("ch1_div_applied", 32'(ch_full), 32'd4);
        check_val("ch_clk_idle", 32'(ch_clk), 32'd0);

        // both dividers drain the reset count in lockstep, so ch0/ch1 rise together
        k = 0;
        while (ch_ce[0] !== 1'b1 && k < 30000) begin
            step(1);
            k++;
        end
        check_val("ch0_first_rise", 32'(ch_ce[0]), 32'd1);
        check_val("ch01_rise_together", 32'(ch_clk), 32'd3);

        hi = 0;
        ce = 0;
        for (int i = 0; i < 8; i++) begin
            hi += int'(ch_clk[0]);
            ce += int'(ch_ce[0]);
            step(1);
        end
        check_val("ch0_high_cycles", 32'(hi), 32'd4);
        check_val("ch0_ce_per_period", 32'(ce), 32'd1);
        check_val("ch0_period_rise_ce", 32'(ch_ce[0]), 32'd1);
        check_val("ch0_period_rise_clk", 32'(ch_clk[0]), 32'd1);

        // ch1 just rose: switch it to FULL, must wait for the falling toggle
        check_val("ch1_rise", 32'(ch_ce[1]), 32'd1);
        cfg_write(4'h8, 24'h000101);
        check_val("ch1_pend_ready",  32'(cfg_ready), 32'd0);
        check_val("ch1_pend_clk_hi", 32'(ch_clk[1]), 32'd1);
        check_val("ch1_pend_full",   32'(ch_full),   32'd4);
        step(1);
        check_val("ch1_fall_clk",   32'(ch_clk[1]), 32'd0);
        check_val("ch1_fall_full",  32'(ch_full),   32'd4);
        check_val("ch1_fall_ready", 32'(cfg_ready), 32'd0);
        step(1);
        check_val("ch1_full_applied", 32'(ch_full),   32'd6);
        check_val("ch1_ready_back",   32'(cfg_ready), 32'd1);
        check_val("ch1_clk_low",      32'(ch_clk[1]), 32'd0);

        // ch2 idle low: change visible one cycle after acceptance
        cfg_write(4'h8, 24'h000200);
        check_val("ch2_off_full", 32'(ch_full), 32'd2);
        check_val("ch2_off_ready", 32'(cfg_ready), 32'd1);
        cfg_write(4'h8, 24'h000201);
        check_val("ch2_full_again", 32'(ch_full), 32'd6);

        // timer: period 2, enable, target ch2, alt DIV/div0 -> expiry every 12 cycles
        cfg_write(4'h9, 24'h004502);
        k = 0;
        while (timer_evt !== 1'b1 && k < 40) begin
            step(1);
            k++;
        end
        check_val("tmr_first_evt_delay", 32'(k), 32'd12);
        check_val("tmr_ch2_to_div_full", 32'(ch_full[2]), 32'd0);
        check_val("tmr_ch2_clk_low", 32'(ch_clk[2]), 32'd0);
        k    = 0;
        seen = 1'b0;
        do begin
            step(1);
            k++;
            if (ch_ce[2] === 1'b1) seen = 1'b1;
        end while (timer_evt !== 1'b1 && k < 40);
        check_val("tmr_second_evt_delay", 32'(k), 32'd12);
        check_val("tmr_ch2_div_toggled", 32'(seen), 32'd1);
        k = 0;
        while (ch_full[2] !== 1'b1 && k < 8) begin
            step(1);
            k++;
        end
        check_val("tmr_ch2_back_full", 32'(ch_full[2]), 32'd1);

        // period 0, target ch1, alt OFF; write ch1 DIV/div1 exactly in the expiry cycle
        cfg_write(4'h9, 24'h000300);
        step(3);
        check_val("col_pre_evt", 32'(timer_evt), 32'd0);
        check_val("col_pre_ready", 32'(cfg_ready), 32'd1);
        cfg_write(4'h8, 24'h000106);
        check_val("col_evt_pulse", 32'(timer_evt), 32'd1);
        check_val("col_write_wins", 32'(ch_full[1]), 32'd0);
        step(4);
        check_val("col_next_evt", 32'(timer_evt), 32'd1);
        step(2);
        check_val("col_alt_off_full", 32'(ch_full[1]), 32'd0);
        check_val("col_alt_off_clk", 32'(ch_clk[1]), 32'd0);
        check_val("col_ready", 32'(cfg_ready), 32'd1);

        // disable timer: no further events
        cfg_write(4'h9, 24'h000000);
        evts = 0;
        for (int i = 0; i < 12; i++) begin
            evts += int'(timer_evt);
            step(1);
        end
        check_val("tmr_disabled_evts", 32'(evts), 32'd0);

        // ignored writes: channel 5, DIV with missing divider, reload addr 7
        cfg_write(4'h8, 24'h000501);
        check_val("ign_ch5_full", 32'(ch_full), 32'd4);
        check_val("ign_ch5_ready", 32'(cfg_ready), 32'd1);
        cfg_write(4'h8, 24'h00020E);
        check_val("ign_badsel_full", 32'(ch_full), 32'd4);
        cfg_write(4'h7, 24'd2);
        check_val("ign_rld7_ready", 32'(cfg_ready), 32'd1);

        // reset mid-operation
        reset = 1'b1;
        step(2);
        check_val("rst2_full",  32'(ch_full),   32'd7);
        check_val("rst2_clk",   32'(ch_clk),    32'd0);
        check_val("rst2_ready", 32'(cfg_ready), 32'd1);
        check_val("rst2_evt",   32'(timer_evt), 32'd0);
        reset = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pmu_clock_ctrl.md
Name: pmu_clock_ctrl

Overview:
- Parametrised power-management clock controller: CHANNELS output clocks, each independently OFF, FULL (raw clk selected downstream) or DIV (toggle clock from one of DIVIDERS programmable dividers).
- Runtime reconfiguration through a valid/ready config port.
- Mode changes are glitch-safe: they are applied only while the channel clock is low.
- Built-in seconds timer periodically ping-pongs one channel between two configurations, generalising the fixed timer-driven clock switching of the current PMU.

Parameters:
- CHANNELS, 3, number of output clock channels (1..16)
- DIVIDERS, 3, number of shared down-counting dividers (1..8)
- DIV_WIDTH, 21, divider counter/reload width (1..24)
- DIV_DEFAULT, 21'h5000, reset reload value of every divider
- RESET_MODE, 2'b01, reset mode of every channel (00 OFF, 01 FULL, 10 DIV)
- TICK_CYCLES, 12000000, clk cycles per timer second
- TIMER_DEFAULT, 20, reset timer period in seconds (8-bit)

Ports:
- clk  in  1  master clock
- reset  in  1  synchronous reset, active-high
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config port can accept a write
- cfg_addr  in  4  register address
- cfg_data  in  24  write data
- ch_clk  out  CHANNELS  registered divided clock per channel
- ch_ce  out  CHANNELS  1-cycle pulse on each ch_clk rising toggle
- ch_full  out  CHANNELS  1 = channel in FULL mode; downstream muxes raw clk
- timer_evt  out  1  1-cycle pulse on timer expiry

Behaviour:
- The already-decided fixed point: one clock, `clk`; `reset` is synchronous and active-high.
- Reset:
  - Divider counters and reloads = DIV_DEFAULT; all channels mode RESET_MODE, divider select 0.
  - ch_clk = 0, ch_ce = 0, ch_full = (RESET_MODE==01), timer_evt = 0, cfg_ready = 1.
  - Timer disabled, period = TIMER_DEFAULT, all pending changes cleared.
  - Reset mid-operation discards pending/alt state.
- Dividers:
  - Counter decrements each cycle. At 0 it raises tc for that cycle and reloads from its reload register, so tc period = reload+1 cycles.
  - A reload write takes effect at the next reload; the running count is not disturbed.
  - Reload 0: tc every cycle.
- Channel modes:
  - OFF (00, and reserved 11): ch_clk held 0, ch_full = 0.
  - FULL: ch_clk held 0, ch_full = 1.
  - DIV: ch_clk toggles in the cycle after the selected divider's tc, giving a period of 2*(reload+1). ch_ce = 1 in the cycle ch_clk goes 0->1.
- Register map, writes accepted on cfg_valid && cfg_ready:
  - 0x0-0x7: reload of divider addr, from data[DIV_WIDTH-1:0]. addr >= DIVIDERS is ignored.
  - 0x8: channel config. data[11:8] channel, data[1:0] mode, data[5:2] divider select. Written into the channel's pending slot. Ignored if channel >= CHANNELS, or if mode = DIV with select >= DIVIDERS.
  - 0x9: timer. data[7:0] period, data[8] enable, data[12:9] target channel, data[14:13] alt mode, data[18:15] alt divider.
  - Any write to 0x9 restarts the prescaler and the seconds counter.
  - 0xA-0xF: ignored.
- Glitch-safe apply:
  - A pending config is applied on the first cycle where the channel's ch_clk register is 0.
  - If ch_clk is already 0, the change is visible 1 cycle after acceptance.
  - If ch_clk is 1, the change applies the cycle after the next falling toggle.
  - cfg_ready = 0 while any channel has a pending change.
- Timer:
  - Prescaler counts TICK_CYCLES-1 down to 0; each wrap is one second tick.
  - The seconds counter counts period down. On a tick at 0: timer_evt = 1 for one cycle, and the counter reloads the period.
  - When disabled, both counters are held at their reload values and timer_evt = 0.
  - On expiry while enabled, the target channel's current config and alt config swap. The new config goes through the pending (glitch-safe) path.
  - Period 0 gives expiry on every tick.
- Simultaneous events:
  - A config write to the same channel in the same cycle as a timer swap wins; the swap is dropped but timer_evt still pulses.
  - A reload write coinciding with tc: tc reloads the old value and the new value is used from the next reload.

Test Plan:
- Reset with defaults, 8 cycles -> ch_full = 3'b111, ch_clk = 0, ch_ce = 0, cfg_ready = 1, timer_evt = 0.
- DIVIDERS=3; write reload 0x0 = 3, then ch0 DIV/div0 -> ch_clk[0] period 8 cycles, 4 high/4 low. ch_ce[0] pulses once per 8 cycles.
- ch1 DIV with reload 1 and ch_clk[1] high; write ch1 FULL -> cfg_ready drops, and ch_full[1] rises only after ch_clk[1] falls. No ch_clk[1] pulse narrower than 2 cycles.
- TICK_CYCLES=4, timer period 2, enable, target ch2, alt DIV/div0 -> timer_evt every 12 cycles. ch2 alternates FULL <-> DIV on successive events.
- Write ch0 cfg in the exact expiry cycle targeting ch0 -> written config applied; alt unchanged; timer_evt = 1.
- Write channel index 5 with CHANNELS=3, and reload addr 0x7 -> no state change; cfg_ready stays 1.
